// File: rtl/elastic_buffer_ml.sv
// Multi-lane JESD204B receive elastic buffer. Per-lane FIFOs start filling on their own
// data_ready edge and are released together a programmable delay after a SYSREF edge.
module elastic_buffer_ml #(
    parameter int unsigned LANES   = 2,
    parameter int unsigned W       = 32,
    parameter int unsigned DEPTH   = 64,
    parameter int unsigned DELAY_W = 10,
    localparam int unsigned AW     = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clear,
    input  logic [LANES-1:0]        data_ready,
    input  logic                    sysref,
    input  logic [DELAY_W-1:0]      release_delay,
    input  logic [LANES*W-1:0]      data_in,
    output logic [LANES*W-1:0]      data_out,
    output logic                    data_valid,
    output logic                    aligned,
    output logic [LANES*(AW+1)-1:0] usedw,
    output logic [LANES-1:0]        overflow,
    output logic [LANES-1:0]        underflow
);
    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StCount = 2'd1;
    localparam logic [1:0] StRun   = 2'd2;

    logic [1:0]         state_q;
    logic [DELAY_W-1:0] cnt_q;
    logic               sysref_q1;
    logic               sysref_q2;
    logic               valid_q;
    logic [LANES-1:0]   wr_active;
    logic [LANES-1:0]   lane_empty;
    logic               run;
    logic               sysref_rise;

    assign run         = (state_q == StRun);
    assign sysref_rise = sysref_q1 & ~sysref_q2;
    assign aligned     = run;
    assign data_valid  = valid_q;

    // Release FSM shared by all lanes; SYSREF only counts once every lane is writing.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            sysref_q1 <= 1'b0;
            sysref_q2 <= 1'b0;
            valid_q   <= 1'b0;
        end else if (clear) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            sysref_q1 <= 1'b0;
            sysref_q2 <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            sysref_q1 <= sysref;
            sysref_q2 <= sysref_q1;
            valid_q   <= run & ~|lane_empty;
            case (state_q)
                StIdle: begin
                    if (sysref_rise && (&wr_active)) begin
                        state_q <= StCount;
                        cnt_q   <= release_delay;
                    end
                end
                StCount: begin
                    if (cnt_q == '0) begin
                        state_q <= StRun;
                    end else begin
                        cnt_q <= cnt_q - DELAY_W'(1);
                    end
                end
                StRun:   state_q <= StRun;
                default: state_q <= StIdle;
            endcase
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [W-1:0] din_q1;
        logic [W-1:0] din_q2;
        logic [W-1:0] dout_q;
        logic         dr_q1;
        logic         dr_q2;
        logic         active_q;
        logic         ovf_q;
        logic         udf_q;
        logic [AW:0]  wptr_q;
        logic [AW:0]  rptr_q;
        logic [W-1:0] mem [DEPTH];
        logic         empty;
        logic         full;
        logic         wr_en;
        logic         wr_ok;
        logic         rd_ok;

        assign empty = (wptr_q == rptr_q);
        assign full  = (wptr_q == {~rptr_q[AW], rptr_q[AW-1:0]});
        assign wr_en = active_q & dr_q2;
        assign rd_ok = run & ~empty;
        // A full lane still takes the write when the same cycle frees a slot.
        assign wr_ok = wr_en & (~full | rd_ok);

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                din_q1   <= '0;
                din_q2   <= '0;
                dout_q   <= '0;
                dr_q1    <= 1'b0;
                dr_q2    <= 1'b0;
                active_q <= 1'b0;
                ovf_q    <= 1'b0;
                udf_q    <= 1'b0;
                wptr_q   <= '0;
                rptr_q   <= '0;
            end else if (clear) begin
                din_q1   <= '0;
                din_q2   <= '0;
                dout_q   <= '0;
                dr_q1    <= 1'b0;
                dr_q2    <= 1'b0;
                active_q <= 1'b0;
                ovf_q    <= 1'b0;
                udf_q    <= 1'b0;
                wptr_q   <= '0;
                rptr_q   <= '0;
            end else begin
                din_q1 <= data_in[k*W +: W];
                din_q2 <= din_q1;
                dr_q1  <= data_ready[k];
                dr_q2  <= dr_q1;
                if (dr_q1 && !dr_q2) begin
                    active_q <= 1'b1;
                end
                if (wr_ok) begin
                    wptr_q <= wptr_q + (AW+1)'(1);
                end
                if (wr_en && !wr_ok) begin
                    ovf_q <= 1'b1;
                end
                if (rd_ok) begin
                    rptr_q <= rptr_q + (AW+1)'(1);
                    dout_q <= mem[rptr_q[AW-1:0]];
                end
                if (run && empty) begin
                    udf_q <= 1'b1;
                end
            end
        end

        always_ff @(posedge clk) begin
            if (wr_ok) begin
                mem[wptr_q[AW-1:0]] <= din_q2;
            end
        end

        assign wr_active[k]                = active_q;
        assign lane_empty[k]               = empty;
        assign data_out[k*W +: W]          = dout_q;
        assign usedw[k*(AW+1) +: (AW+1)]   = wptr_q - rptr_q;
        assign overflow[k]                 = ovf_q;
        assign underflow[k]                = udf_q;
    end

endmodule

// File: tb/tb_elastic_buffer_ml.sv
// Bench for elastic_buffer_ml: directed release scenarios plus randomized rounds, all checked
// every cycle against a queue-based model that works in absolute edge numbers.
module tb_elastic_buffer_ml;
    localparam int LANES   = 2;
    localparam int W       = 32;
    localparam int DEPTH   = 64;
    localparam int DELAY_W = 10;
    localparam int AW      = 6;

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    clear;
    logic [LANES-1:0]        data_ready;
    logic                    sysref;
    logic [DELAY_W-1:0]      release_delay;
    logic [LANES*W-1:0]      data_in;
    logic [LANES*W-1:0]      data_out;
    logic                    data_valid;
    logic                    aligned;
    logic [LANES*(AW+1)-1:0] usedw;
    logic [LANES-1:0]        overflow;
    logic [LANES-1:0]        underflow;

    always #5 clk = ~clk;

    elastic_buffer_ml #(
        .LANES  (LANES),
        .W      (W),
        .DEPTH  (DEPTH),
        .DELAY_W(DELAY_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .clear        (clear),
        .data_ready   (data_ready),
        .sysref       (sysref),
        .release_delay(release_delay),
        .data_in      (data_in),
        .data_out     (data_out),
        .data_valid   (data_valid),
        .aligned      (aligned),
        .usedw        (usedw),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: one queue per lane, release expressed as an absolute run-start edge.
    logic [W-1:0]     mq0[$];
    logic [W-1:0]     mq1[$];
    logic [LANES-1:0] m_dr1, m_dr2;
    logic [W-1:0]     m_din1 [LANES];
    logic [W-1:0]     m_din2 [LANES];
    logic             m_sr1, m_sr2;
    int               m_armed [LANES];
    bit               m_acc;
    int               m_run_from;
    logic [W-1:0]     m_dout [LANES];
    bit               m_valid;
    bit               m_aligned;
    logic [LANES-1:0] m_ovf, m_udf;
    int               n_edge = 0;

    logic             rand_data;
    logic [W-1:0]     lane_cnt [LANES];

    function automatic int qsize(input int k);
        return (k == 0) ? mq0.size() : mq1.size();
    endfunction

    task automatic qpush(input int k, input logic [W-1:0] v);
        if (k == 0) mq0.push_back(v);
        else mq1.push_back(v);
    endtask

    task automatic qpop(input int k, output logic [W-1:0] v);
        if (k == 0) v = mq0.pop_front();
        else v = mq1.pop_front();
    endtask

    task automatic model_reset();
        mq0.delete();
        mq1.delete();
        m_dr1 = '0;
        m_dr2 = '0;
        m_sr1 = 1'b0;
        m_sr2 = 1'b0;
        for (int k = 0; k < LANES; k++) begin
            m_din1[k]  = '0;
            m_din2[k]  = '0;
            m_armed[k] = -1;
            m_dout[k]  = '0;
        end
        m_acc      = 1'b0;
        m_run_from = 0;
        m_valid    = 1'b0;
        m_aligned  = 1'b0;
        m_ovf      = '0;
        m_udf      = '0;
    endtask

    // A lane counts as writing at edge n once its rising edge was sampled at edge <= n-2.
    function automatic bit lane_live(input int k, input int n);
        return (m_armed[k] >= 0) && (m_armed[k] <= n - 2);
    endfunction

    task automatic model_edge();
        bit           all_ne;
        bit           all_live;
        logic [W-1:0] v;
        if (clear) begin
            model_reset();
        end else begin
            if (m_acc && n_edge > m_run_from) begin
                all_ne = 1'b1;
                for (int k = 0; k < LANES; k++) begin
                    if (qsize(k) == 0) begin
                        m_udf[k] = 1'b1;
                        all_ne   = 1'b0;
                    end else begin
                        qpop(k, v);
                        m_dout[k] = v;
                    end
                end
                m_valid = all_ne;
            end else begin
                m_valid = 1'b0;
            end
            for (int k = 0; k < LANES; k++) begin
                if (m_dr2[k] && lane_live(k, n_edge)) begin
                    if (qsize(k) < DEPTH) qpush(k, m_din2[k]);
                    else m_ovf[k] = 1'b1;
                end
            end
            all_live = 1'b1;
            for (int k = 0; k < LANES; k++) begin
                if (!lane_live(k, n_edge)) all_live = 1'b0;
            end
            if (!m_acc && m_sr1 && !m_sr2 && all_live) begin
                m_acc      = 1'b1;
                m_run_from = n_edge + 1 + int'(release_delay);
            end
            for (int k = 0; k < LANES; k++) begin
                if (m_armed[k] < 0 && data_ready[k] && !m_dr1[k]) m_armed[k] = n_edge;
            end
            m_dr2 = m_dr1;
            m_dr1 = data_ready;
            m_sr2 = m_sr1;
            m_sr1 = sysref;
            for (int k = 0; k < LANES; k++) begin
                m_din2[k] = m_din1[k];
                m_din1[k] = data_in[k*W +: W];
            end
            m_aligned = m_acc && (n_edge >= m_run_from);
        end
        n_edge++;
    endtask

    task automatic check_all();
        check("data_out", 64'(data_out), 64'({m_dout[1], m_dout[0]}));
        check("data_valid", 64'(data_valid), 64'(m_valid));
        check("aligned", 64'(aligned), 64'(m_aligned));
        check("usedw", 64'(usedw), 64'({7'(qsize(1)), 7'(qsize(0))}));
        check("overflow", 64'(overflow), 64'(m_ovf));
        check("underflow", 64'(underflow), 64'(m_udf));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    // Lane k sends base + number of cycles its data_ready has been high, or random words.
    task automatic drive(input logic [1:0] dr, input logic sr, input logic clr);
        data_ready = dr;
        sysref     = sr;
        clear      = clr;
        for (int k = 0; k < LANES; k++) begin
            if (rand_data) data_in[k*W +: W] = $urandom;
            else data_in[k*W +: W] = ((k == 1) ? 32'h1000 : 32'h0) + lane_cnt[k];
            if (dr[k]) lane_cnt[k] = lane_cnt[k] + 1;
        end
    endtask

    task automatic reset_counters();
        for (int k = 0; k < LANES; k++) lane_cnt[k] = '0;
    endtask

    task automatic do_clear();
        drive(2'b00, 1'b0, 1'b1);
        cycle();
        clear = 1'b0;
        reset_counters();
    endtask

    task automatic check_zero(input string pfx);
        check({pfx, "_data_out"}, 64'(data_out), 64'(0));
        check({pfx, "_data_valid"}, 64'(data_valid), 64'(0));
        check({pfx, "_aligned"}, 64'(aligned), 64'(0));
        check({pfx, "_usedw"}, 64'(usedw), 64'(0));
        check({pfx, "_overflow"}, 64'(overflow), 64'(0));
        check({pfx, "_underflow"}, 64'(underflow), 64'(0));
    endtask

    task automatic do_reset();
        #2 reset = 1'b1;
        #1;
        check_zero("async_rst");
        data_ready = '0;
        sysref     = 1'b0;
        clear      = 1'b0;
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        reset_counters();
    endtask

    initial begin
        logic [1:0] dr;
        int rise0, rise1, sa, sb;
        reset         = 1'b1;
        clear         = 1'b0;
        data_ready    = '0;
        sysref        = 1'b0;
        release_delay = '0;
        data_in       = '0;
        rand_data     = 1'b0;
        reset_counters();
        model_reset();
        repeat (2) @(negedge clk);
        check_zero("reset");
        reset = 1'b0;

        // Basic release, then lane 0 starves for 40 cycles.
        do_clear();
        release_delay = 10'd10;
        for (int c = 0; c < 140; c++) begin
            dr = 2'b11;
            if (c >= 60 && c < 100) dr[0] = 1'b0;
            drive(dr, c == 20, 1'b0);
            cycle();
            if (c == 31) check("basic_aligned_early", 64'(aligned), 64'(0));
            if (c == 32) check("basic_aligned", 64'(aligned), 64'(1));
            if (c == 32) check("basic_valid_early", 64'(data_valid), 64'(0));
            if (c == 33) check("basic_valid", 64'(data_valid), 64'(1));
            if (c == 33) check("basic_first", 64'(data_out), 64'h0000_1000_0000_0000);
            if (c == 59) check("basic_usedw", 64'(usedw), 64'({7'd31, 7'd31}));
            if (c == 59) check("basic_stream", 64'(data_out), 64'h0000_101A_0000_001A);
            if (c == 92) check("udf_early", 64'(underflow), 64'(0));
            if (c == 93) check("udf_set", 64'(underflow), 64'(2'b01));
            if (c == 93) check("udf_valid", 64'(data_valid), 64'(0));
            if (c == 95) check("udf_hold", 64'(data_out[31:0]), 64'd59);
        end
        do_clear();
        check_zero("clear");

        // Lane skew: lane 1 starts 5 cycles late.
        release_delay = 10'd10;
        for (int c = 0; c < 45; c++) begin
            drive({c >= 5, 1'b1}, c == 20, 1'b0);
            cycle();
            if (c == 33) check("skew_first", 64'(data_out), 64'h0000_1000_0000_0000);
            if (c == 33) check("skew_valid", 64'(data_valid), 64'(1));
            if (c == 44) check("skew_usedw", 64'(usedw), 64'({7'd26, 7'd31}));
        end

        // SYSREF gating: early pulse ignored, second one releases.
        do_clear();
        for (int c = 0; c < 50; c++) begin
            drive({c >= 5, 1'b1}, (c == 3) || (c == 30), 1'b0);
            cycle();
            if (c == 29) check("gate_ignored", 64'(aligned), 64'(0));
            if (c == 41) check("gate_aligned_early", 64'(aligned), 64'(0));
            if (c == 42) check("gate_aligned", 64'(aligned), 64'(1));
            if (c == 43) check("gate_valid", 64'(data_valid), 64'(1));
            if (c == 43) check("gate_first", 64'(data_out), 64'h0000_1000_0000_0000);
        end

        // Zero release delay.
        do_clear();
        release_delay = '0;
        for (int c = 0; c < 20; c++) begin
            drive(2'b11, c == 10, 1'b0);
            cycle();
            if (c == 11) check("d0_aligned_early", 64'(aligned), 64'(0));
            if (c == 12) check("d0_aligned", 64'(aligned), 64'(1));
            if (c == 13) check("d0_valid", 64'(data_valid), 64'(1));
        end

        // Overflow with a long delay, then an asynchronous reset mid-stream.
        do_clear();
        release_delay = 10'd100;
        for (int c = 0; c < 140; c++) begin
            drive(2'b11, c == 20, 1'b0);
            cycle();
            if (c == 65) check("ovf_full", 64'(usedw), 64'({7'd64, 7'd64}));
            if (c == 65) check("ovf_early", 64'(overflow), 64'(0));
            if (c == 66) check("ovf_set", 64'(overflow), 64'(2'b11));
            if (c == 121) check("ovf_aligned_early", 64'(aligned), 64'(0));
            if (c == 122) check("ovf_aligned", 64'(aligned), 64'(1));
            if (c == 123) check("ovf_first", 64'(data_out), 64'h0000_1000_0000_0000);
            if (c == 139) check("ovf_usedw_run", 64'(usedw), 64'({7'd64, 7'd64}));
            if (c == 139) check("ovf_sticky", 64'(overflow), 64'(2'b11));
        end
        do_reset();
        for (int c = 0; c < 3; c++) begin
            drive(2'b00, 1'b0, 1'b0);
            cycle();
        end
        check("rst_idle", 64'(aligned), 64'(0));

        // Randomized rounds with dropouts, stray clears and one mid-run reset.
        rand_data = 1'b1;
        for (int r = 0; r < 8; r++) begin
            do_clear();
            release_delay = DELAY_W'($urandom_range(0, 20));
            rise0 = $urandom_range(0, 15);
            rise1 = $urandom_range(0, 15);
            sa    = $urandom_range(0, 25);
            sb    = sa + $urandom_range(2, 30);
            for (int c = 0; c < 120; c++) begin
                dr[0] = (c >= rise0) && ($urandom_range(0, 15) != 0);
                dr[1] = (c >= rise1) && ($urandom_range(0, 15) != 0);
                if (r == 3 && c == 60) do_reset();
                drive(dr, (c == sa) || (c == sb), $urandom_range(0, 299) == 0);
                cycle();
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/elastic_buffer_ml.md
# elastic_buffer_ml

Multi-lane, parametrised JESD204B receive elastic buffer with a programmable release delay. Each lane gets its own on-chip FIFO, and each FIFO starts filling on that lane's `data_ready` rising edge. All lanes are then released together, a run-time-programmable number of cycles after a SYSREF rising edge, which gives deterministic latency and lane-to-lane alignment. The block sits between the per-lane descrambler/link-layer outputs and the transport-layer sample demapper. It adds per-lane occupancy, sticky overflow/underflow flags and a synchronous flush.

## Interface
- `LANES`, 2: number of lanes, 1..8.
- `W`, 32: data width per lane.
- `DEPTH`, 64: FIFO depth per lane; a power of two, 8..1024. `AW = log2(DEPTH)`.
- `DELAY_W`, 10: width of `release_delay`.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `clear` in 1: synchronous flush, one-cycle pulse or level.
- `data_ready` in LANES: per-lane. A rising edge arms writing; the level gates writes.
- `sysref` in 1: release trigger; rising edge only.
- `release_delay` in DELAY_W: cycles inserted between SYSREF detection and read start.
- `data_in` in LANES*W: lane k occupies bits `[k*W +: W]`.
- `data_out` out LANES*W: aligned output, same packing as `data_in`.
- `data_valid` out 1: `data_out` holds a freshly read word on all lanes.
- `aligned` out 1: release FSM is in RUN.
- `usedw` out LANES*(AW+1): per-lane occupancy 0..DEPTH.
- `overflow` out LANES: sticky; a write was dropped because the lane FIFO was full.
- `underflow` out LANES: sticky; a read was attempted while the lane FIFO was empty.

## Operation
- Write path (per lane):
  - `data_in` and `data_ready` each pass through a 2-stage register pipeline.
  - Edge detect on `data_ready` registers `start = ~dr_q & data_ready`. `wr_active` is set sticky on `start`.
  - Write enable = `wr_active & data_ready` delayed by 2 stages.
  - The FIFO is implemented in-block as a register array or inferred RAM, with `AW+1`-bit read/write pointers. No vendor IP.
- Full handling:
  - A write to a full lane is dropped and sets `overflow[k]`.
  - A write coinciding with a read of the same lane is always accepted.
- Release FSM (shared by all lanes), with `sysref` edge detected the same way as `data_ready`:
  - IDLE → COUNT on a sysref pulse, only if every lane's `wr_active` = 1; otherwise the pulse is ignored. On entry, `cnt <= release_delay`.
  - COUNT: `cnt` decrements; when `cnt == 0`, go to RUN at the next edge.
  - RUN: all lanes are read every cycle. Further sysref edges are ignored in COUNT and RUN.
  - Any state → IDLE on `clear`.
- Read:
  - For each lane: if not empty, pop the lane and register the word into `data_out`.
  - If empty: hold the lane's `data_out`, do not advance that lane's pointer, and set `underflow[k]`.
  - `data_valid` is registered as: in RUN and no lane empty.
- `usedw` is updated every cycle: +1 on an accepted write, −1 on a successful read, unchanged when both occur.
- `clear` zeroes pointers, `usedw`, flags, `wr_active`, pipelines, `data_out` and `data_valid`. Each lane then needs a new `data_ready` rising edge.

## Timing
- Reset values: all outputs are 0 (`data_out`, `data_valid`, `aligned`, `usedw`, `overflow`, `underflow`). The FSM is in IDLE.
- Write start: `data_ready` is first sampled high at edge E0, so `wr_active` = 1 from E1. The first write occurs at E2 and stores the `data_in` sampled at E0.
- Release timing, with `sysref` first sampled high at edge S0 and D = `release_delay`:
  - COUNT is entered at S1 and RUN at S2+D, so `aligned` = 1 from S2+D.
  - The first read is at edge S3+D, when `data_out` and `data_valid` update.
  - The sysref-to-first-valid latency is therefore D+3.
- D = 0 is legal: RUN is entered at S2.
- Lanes that start at different cycles keep their own skew in the FIFO and emit their respective first words on the same cycle.
- With continuous writes, each lane's `usedw` is constant in RUN and equals the number of writes accepted before S3+D.
- `reset` mid-operation takes effect immediately and asynchronously. `clear` takes effect at the next edge and overrides a coincident sysref or `data_ready` edge.

## Test plan
- Reset check: assert `reset` mid-stream → all outputs read 0 within the same cycle. After release, the FSM is in IDLE and `aligned` = 0.
- Basic release:
  - Stimulus: LANES=2, `data_in` = per-lane counter starting at 0 (lane 1 offset by 0x1000), both `data_ready` rising at cycle 0, `sysref` high at cycle 20, D=10.
  - Required response: `aligned` rises at cycle 32. First `data_valid` at cycle 33 with `data_out` = {0x1000, 0x0000}, then incrementing by 1 per cycle with no gaps. `usedw` = 31 on both lanes in steady state.
- Lane skew: as in the basic release, but lane 1 `data_ready` rises at cycle 5 → the first valid word is {0x1000, 0x0000} on the same cycle. Lane 1 `usedw` is 5 lower than lane 0.
- SYSREF gating: `sysref` pulses at cycle 3, when lane 1 is not yet active → ignored and `aligned` stays 0. A second pulse after both lanes are active → release with latency D+3.
- Overflow: DEPTH=64, D=100 → `usedw` saturates at 64. `overflow` = 2'b11 from the first dropped write and stays sticky through RUN until `clear`.
- Underflow and clear:
  - Stimulus: in RUN, drop lane 0 `data_ready` for 40 cycles with `usedw` = 31.
  - Required response: `underflow[0]` sets when lane 0 `usedw` reaches 0, `data_valid` deasserts, and lane 0 `data_out` holds its value. Pulsing `clear` zeroes all flags and counts and returns the FSM to IDLE.
